// File: rtl/i2s_tx.sv
// I2S transmitter: serialises left/right sample pairs onto sdata, MSB one SCLK after each lrck transition.
// Runs entirely on mclk; sclk/lrck are sampled and their falling/changing edges detected internally.
module i2s_tx #(
  parameter int DATA_WIDTH = 24,
  parameter int SLOT_WIDTH = 32
) (
  input  logic                  mclk,
  input  logic                  arstn,
  input  logic                  lrck,
  input  logic                  sclk,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_left,
  input  logic [DATA_WIDTH-1:0] s_right,
  output logic                  sdata,
  output logic                  underrun,
  output logic                  slot_err
);

  localparam int CNT_W = $clog2(SLOT_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;

  state_t                  state_q, state_d;
  logic [SLOT_WIDTH-1:0]   shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0]   r_hold_q, r_hold_d;
  logic [DATA_WIDTH-1:0]   l_buf_q, l_buf_d;
  logic [DATA_WIDTH-1:0]   r_buf_q, r_buf_d;
  logic                    full_q, full_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    sclk_q, sclk_d;
  logic                    lrck_q, lrck_d;
  logic                    sdata_q, sdata_d;
  logic                    underrun_q, underrun_d;
  logic                    slot_err_q, slot_err_d;

  logic fall_ev;
  logic lr_edge;
  logic xfer;
  logic cnt_bad;

  // Left-justify a sample in its slot; the trailing bits are zero.
  function automatic logic [SLOT_WIDTH-1:0] align_msb(input logic [DATA_WIDTH-1:0] w);
    align_msb = SLOT_WIDTH'(w) << (SLOT_WIDTH - DATA_WIDTH);
  endfunction

  assign fall_ev  = sclk_q & ~sclk;
  assign lr_edge  = fall_ev & (lrck_q ^ lrck);
  assign xfer     = s_valid & ~full_q;
  assign cnt_bad  = (cnt_q != CNT_W'(SLOT_WIDTH - 1));

  assign s_ready  = ~full_q;
  assign sdata    = sdata_q;
  assign underrun = underrun_q;
  assign slot_err = slot_err_q;

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    r_hold_d   = r_hold_q;
    l_buf_d    = l_buf_q;
    r_buf_d    = r_buf_q;
    full_d     = full_q;
    cnt_d      = cnt_q;
    sclk_d     = sclk;
    lrck_d     = lrck;
    sdata_d    = sdata_q;
    underrun_d = 1'b0;
    slot_err_d = slot_err_q;

    if (fall_ev) begin
      if (lr_edge && !lrck) begin
        if (state_q != IDLE && cnt_bad) slot_err_d = 1'b1;
        sdata_d = shreg_q[SLOT_WIDTH-1];
        state_d = LEFT;
        cnt_d   = '0;
        if (full_q) begin
          shreg_d  = align_msb(l_buf_q);
          r_hold_d = r_buf_q;
          full_d   = 1'b0;
        end else begin
          shreg_d    = '0;
          r_hold_d   = '0;
          underrun_d = 1'b1;
        end
      end else if (lr_edge && lrck) begin
        // A rising lrck before the first frame start is ignored.
        if (state_q != IDLE) begin
          if (cnt_bad) slot_err_d = 1'b1;
          sdata_d = shreg_q[SLOT_WIDTH-1];
          state_d = RIGHT;
          cnt_d   = '0;
          shreg_d = align_msb(r_hold_q);
        end
      end else if (state_q != IDLE) begin
        sdata_d = shreg_q[SLOT_WIDTH-1];
        shreg_d = shreg_q << 1;
        // Saturate so a stalled lrck can never wrap back to a "good" count.
        if (cnt_q != CNT_W'(SLOT_WIDTH)) cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // Only fires when empty, so it never collides with the consumption above.
    if (xfer) begin
      full_d  = 1'b1;
      l_buf_d = s_left;
      r_buf_d = s_right;
    end
  end

  always_ff @(posedge mclk or negedge arstn) begin
    if (!arstn) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      r_hold_q   <= '0;
      full_q     <= 1'b0;
      cnt_q      <= '0;
      sclk_q     <= 1'b0;
      lrck_q     <= 1'b0;
      sdata_q    <= 1'b0;
      underrun_q <= 1'b0;
      slot_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      r_hold_q   <= r_hold_d;
      full_q     <= full_d;
      cnt_q      <= cnt_d;
      sclk_q     <= sclk_d;
      lrck_q     <= lrck_d;
      sdata_q    <= sdata_d;
      underrun_q <= underrun_d;
      slot_err_q <= slot_err_d;
    end
  end

  // Sample storage is qualified by full_q, so it needs no reset.
  always_ff @(posedge mclk) begin
    l_buf_q <= l_buf_d;
    r_buf_q <= r_buf_d;
  end

endmodule
